// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle LOAD/EXEC/WB/DONE control sequencer for the register/ALU datapath
//
// Purpose: accepts one 16-bit instruction over a valid/ready handshake and
// walks it through LOAD -> EXEC -> WB -> DONE. It drives the operand-load,
// ALU-capture and register-write strobes for the datapath.
//
// Optional feature macro: PERF_COUNTERS_EN adds the retired_cnt and stall_cnt outputs.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   run                 global enable; low freezes the sequence and gates strobes
//   instr_valid         instruction available
//   instruction[IW]     Rx[15:13] Ry[12:10] imm8[12:5] sel[4:2] fmt[1:0]
//   instr_ready         sequencer can accept this cycle (IDLE or DONE)
//   en_s, imm_sel       operand load strobe / immediate operand select (LOAD)
//   en_c                ALU result capture (last EXEC cycle)
//   en_reg[NREGS]       one-hot register write enable (WB)
//   cur_rx/ry/sel       latched instruction fields
//   busy, done, illegal state != IDLE, retire pulse, retire of fmt==2
//   retired_cnt, stall_cnt  (PERF_COUNTERS_EN only) retire count, frozen-busy cycles
module alu_op_sequencer #(
  parameter int NREGS   = 8,
  parameter int ALU_LAT = 1,
  parameter int IW      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             instr_valid,
  input  logic [IW-1:0]    instruction,
  output logic             instr_ready,
  output logic             en_s,
  output logic             imm_sel,
  output logic             en_c,
  output logic [NREGS-1:0] en_reg,
  output logic [2:0]       cur_rx,
  output logic [2:0]       cur_ry,
  output logic [2:0]       cur_sel,
  output logic             busy,
  output logic             done,
  output logic             illegal
`ifdef PERF_COUNTERS_EN
  ,
  output logic [15:0]      retired_cnt,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_WB,
    S_DONE
  } state_t;

  localparam logic [2:0] LAST_EXEC = 3'(ALU_LAT - 1);

  state_t        state_q;
  logic [2:0]    cnt_q;
  logic [IW-1:0] instr_q;

  logic       live;
  logic       accept;
  logic [1:0] fmt;
  state_t     issue_state;
  logic       unused_imm;

  // imm8 is consumed by the datapath straight from the instruction bus.
  assign unused_imm = ^instr_q[9:5];

  // Strobes are state decodes qualified by run; reset blanks every output.
  assign live        = run && !reset;
  assign fmt         = instr_q[1:0];
  assign instr_ready = live && (state_q == S_IDLE || state_q == S_DONE);
  assign accept      = instr_valid && instr_ready;
  // fmt 3 is a NOP and retires straight from DONE.
  assign issue_state = (instruction[1:0] == 2'd3) ? S_DONE : S_LOAD;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      instr_q <= '0;
    end else if (run) begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            instr_q <= instruction;
            state_q <= issue_state;
          end
        end
        S_LOAD: begin
          cnt_q   <= '0;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == LAST_EXEC) state_q <= S_WB;
        end
        S_WB: state_q <= S_DONE;
        S_DONE: begin
          if (accept) begin
            instr_q <= instruction;
            state_q <= issue_state;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign en_s    = live && (state_q == S_LOAD);
  assign imm_sel = live && (state_q == S_LOAD) && (fmt == 2'd1);
  assign en_c    = live && (state_q == S_EXEC) && (cnt_q == LAST_EXEC);
  assign en_reg  = (live && state_q == S_WB && fmt != 2'd2)
                   ? ({{(NREGS-1){1'b0}}, 1'b1} << instr_q[15:13]) : '0;
  assign done    = live && (state_q == S_DONE);
  assign illegal = live && (state_q == S_DONE) && (fmt == 2'd2);
  assign busy    = !reset && (state_q != S_IDLE);
  assign cur_rx  = reset ? 3'd0 : instr_q[15:13];
  assign cur_ry  = reset ? 3'd0 : instr_q[12:10];
  assign cur_sel = reset ? 3'd0 : instr_q[4:2];

`ifdef PERF_COUNTERS_EN
  logic [15:0] retired_q;
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (done) retired_q <= retired_q + 16'd1;
      if (busy && !run && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer against an expected-strobe queue model
module tb_alu_op_sequencer;

  localparam int ALU_LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instruction = 16'h0000;
  logic        instr_ready, en_s, imm_sel, en_c, busy, done, illegal;
  logic [7:0]  en_reg;
  logic [2:0]  cur_rx, cur_ry, cur_sel;
`ifdef PERF_COUNTERS_EN
  logic [15:0] retired_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  alu_op_sequencer #(.NREGS(8), .ALU_LAT(ALU_LAT), .IW(16)) dut (
    .clk(clk), .reset(reset), .run(run), .instr_valid(instr_valid),
    .instruction(instruction), .instr_ready(instr_ready), .en_s(en_s),
    .imm_sel(imm_sel), .en_c(en_c), .en_reg(en_reg), .cur_rx(cur_rx),
    .cur_ry(cur_ry), .cur_sel(cur_sel), .busy(busy), .done(done),
    .illegal(illegal)
`ifdef PERF_COUNTERS_EN
    , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // One queue entry per run-enabled cycle an instruction occupies the sequencer.
  typedef struct packed {
    logic       en_s;
    logic       imm;
    logic       en_c;
    logic [7:0] en_reg;
    logic       done;
    logic       illegal;
  } exp_t;

  exp_t       q[$];
  logic [2:0] m_rx = 3'd0, m_ry = 3'd0, m_sel = 3'd0;
  logic       m_rdy, m_acc;
  int         m_ret = 0, m_stall = 0;
  int         n_cmp = 0, n_err = 0, cyc = 0;
  int         t_acc, t_s, t_c, t_wb, t_done;
  int         c_s, c_c, c_wb, c_done, c_ill;
  logic       imm_at_s;
  logic [7:0] last_en_reg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_instr(input logic [15:0] ins);
    exp_t       e;
    logic [1:0] f;
    f     = ins[1:0];
    m_rx  = ins[15:13];
    m_ry  = ins[12:10];
    m_sel = ins[4:2];
    if (f == 2'd3) begin
      e = '0; e.done = 1'b1; q.push_back(e);
    end else begin
      e = '0; e.en_s = 1'b1; e.imm = (f == 2'd1); q.push_back(e);
      for (int i = 0; i < ALU_LAT - 1; i++) begin
        e = '0; q.push_back(e);
      end
      e = '0; e.en_c = 1'b1; q.push_back(e);
      e = '0; if (f != 2'd2) e.en_reg = 8'd1 << ins[15:13]; q.push_back(e);
      e = '0; e.done = 1'b1; e.illegal = (f == 2'd2); q.push_back(e);
    end
  endtask

  task automatic clr_ev();
    c_s = 0; c_c = 0; c_wb = 0; c_done = 0; c_ill = 0;
  endtask

  task automatic tick();
    exp_t h;
    logic busy_e;
    @(negedge clk);
    h = '0; busy_e = 1'b0; m_rdy = 1'b0;
    if (!reset) begin
      busy_e = (q.size() != 0);
      m_rdy  = run && (q.size() <= 1);
      if (run && q.size() != 0) h = q[0];
    end
    m_acc = instr_valid && m_rdy;
    check("strobes", {19'd0, en_s, imm_sel, en_c, en_reg, done, illegal}, {19'd0, h});
    check("ready_busy", {30'd0, instr_ready, busy}, {30'd0, m_rdy, busy_e});
    check("cur", {23'd0, cur_rx, cur_ry, cur_sel},
          reset ? 32'd0 : {23'd0, m_rx, m_ry, m_sel});
`ifdef PERF_COUNTERS_EN
    if (cyc > 0) begin
      check("retired_cnt", {16'd0, retired_cnt}, {16'd0, m_ret[15:0]});
      check("stall_cnt", {16'd0, stall_cnt}, (m_stall > 65535) ? 32'hFFFF : m_stall);
    end
`endif
    if (m_acc) t_acc = cyc;
    if (en_s) begin t_s = cyc; c_s++; imm_at_s = imm_sel; end
    if (en_c) begin t_c = cyc; c_c++; end
    if (en_reg != 8'd0) begin t_wb = cyc; c_wb++; last_en_reg = en_reg; end
    if (done) begin t_done = cyc; c_done++; end
    if (illegal) c_ill++;
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      m_rx = 3'd0; m_ry = 3'd0; m_sel = 3'd0;
      m_ret = 0; m_stall = 0;
    end else begin
      if (h.done) m_ret++;
      if (busy_e && !run) m_stall++;
      if (run) begin
        if (q.size() != 0) void'(q.pop_front());
        if (m_acc) push_instr(instruction);
      end
    end
    cyc++;
  endtask

  task automatic issue(input logic [15:0] ins);
    int n;
    n = 0;
    instr_valid = 1'b1;
    instruction = ins;
    do begin
      tick();
      n++;
    end while (!m_acc && n < 20);
    if (!m_acc) check("accept_timeout", 32'd0, 32'd1);
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    if (q.size() != 0) check("drain_timeout", 32'd0, 32'd1);
    tick();
  endtask

  initial begin
    // 1: reset then idle
    tick(); tick();
    reset = 1'b0;
    tick();
    check("t1_idle", {23'd0, busy, instr_ready, en_s, en_c, en_reg[4:0]}, {23'd0, 1'b0, 1'b1, 7'd0});

    // 2: fmt 0 register op
    clr_ev();
    issue(16'h540C);
    drain();
    check("t2_en_s_lat", t_s - t_acc, 1);
    check("t2_en_c_lat", t_c - t_s, ALU_LAT);
    check("t2_wb_lat", t_wb - t_acc, ALU_LAT + 2);
    check("t2_done_lat", t_done - t_acc, ALU_LAT + 3);
    check("t2_en_reg", last_en_reg, 8'h04);
    check("t2_imm", imm_at_s, 0);
    check("t2_sel", cur_sel, 3);

    // 3: fmt 1 immediate op
    clr_ev();
    issue(16'h2541);
    drain();
    check("t3_imm", imm_at_s, 1);
    check("t3_en_reg", last_en_reg, 8'h02);
    check("t3_en_c_lat", t_c - t_s, ALU_LAT);
    check("t3_done_lat", t_done - t_acc, ALU_LAT + 3);

    // 4: NOPs back to back, then illegal fmt
    clr_ev();
    instr_valid = 1'b1;
    instruction = 16'h0003;
    tick(); tick(); tick();
    instr_valid = 1'b0;
    drain();
    check("t4_nop_done", c_done, 3);
    check("t4_nop_strobes", c_s + c_c + c_wb, 0);
    clr_ev();
    issue(16'h0002);
    drain();
    check("t4_ill_done", c_done, 1);
    check("t4_ill_pulse", c_ill, 1);
    check("t4_ill_wb", c_wb, 0);

    // 5: run dropped for 5 cycles during EXEC
    reset = 1'b1; tick(); reset = 1'b0;
    clr_ev();
    issue(16'h540C);
    tick();
    run = 1'b0;
    repeat (5) tick();
    check("t5_busy", busy, 1);
    run = 1'b1;
    drain();
    check("t5_en_c", c_c, 1);
    check("t5_en_reg", c_wb, 1);
    check("t5_done", c_done, 1);
`ifdef PERF_COUNTERS_EN
    check("t5_stall", stall_cnt, 5);
    check("t5_retired", retired_cnt, 1);
`endif

    // 6: reset in the WB cycle abandons the instruction
    clr_ev();
    issue(16'h540C);
    repeat (1 + ALU_LAT) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("t6_no_wb", c_wb, 0);
    check("t6_no_done", c_done, 0);
    check("t6_idle", busy, 0);
    clr_ev();
    issue(16'h540C);
    drain();
    check("t6_after_done", c_done, 1);
    check("t6_after_reg", last_en_reg, 8'h04);

    // Random traffic with run gaps and occasional reset
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 99) < 2);
      run   = ($urandom_range(0, 99) < 85);
      if (!instr_valid || m_acc) begin
        instr_valid = ($urandom_range(0, 99) < 60);
        instruction = 16'($urandom);
      end
      tick();
    end
    reset = 1'b0;
    run = 1'b1;
    instr_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
